// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port block-transfer memory arbiter.
// Holds the FSM state encoding, requester indices and default sizes.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_SZ   = 10;
  localparam int DEF_DATA_SZ   = 32;
  localparam int DEF_BURST_LEN = 4;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way winner select: a lone requester wins outright,
// a tie goes to the requester named by prio.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       win
);

  always_comb begin
    win = 1'b0;
    if (valid == 2'b11) begin
      win = prio;
    end else begin
      win = valid[REQ_DCACHE];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache/D-cache block transfers onto a single-word memory port.
// Define MEM_ARB_FIXED_PRIO_EN to make the D-cache win every tie (no round-robin).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_SZ   = DEF_ADDR_SZ,
  parameter int DATA_SZ   = DEF_DATA_SZ,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [1:0]                    req_valid,
  input  logic [1:0]                    req_write,
  input  logic [1:0][ADDR_SZ-1:0]       req_addr,
  input  logic [1:0][DATA_SZ-1:0]       req_wdata,
  output logic [1:0]                    gnt,
  output logic [$clog2(BURST_LEN)-1:0]  beat,
  output logic [1:0]                    ack,
  output logic                          last,
  output logic [DATA_SZ-1:0]            rdata,
  output logic                          mem_req,
  output logic                          mem_Write,
  output logic [ADDR_SZ-1:0]            mem_addr,
  output logic [DATA_SZ-1:0]            mem_Wdata,
  input  logic [DATA_SZ-1:0]            mem_Rdata,
  input  logic                          mem_Done
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int OFS_W  = BEAT_W + 2;
  localparam logic [ADDR_SZ-1:0] ALIGN_MASK = ~ADDR_SZ'((1 << OFS_W) - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

  arb_state_t          state;
  logic [ADDR_SZ-1:0]  base;
  logic [ADDR_SZ-1:0]  win_base;
  logic [BEAT_W-1:0]   beat_inc;
  logic                prio;
  logic                win;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign prio = 1'b1;
`else
  logic rr_prio;
  assign prio = rr_prio;
`endif

  mem_arb_pick u_pick (
    .valid (req_valid),
    .prio  (prio),
    .win   (win)
  );

  assign win_base = req_addr[win] & ALIGN_MASK;
  assign beat_inc = beat + BEAT_W'(1);

  // The requester derives its write word from beat, which only changes on
  // the same edge as mem_req, so a plain mux is stable for the whole access.
  always_comb begin
    mem_Wdata = '0;
    if (gnt[REQ_DCACHE]) begin
      mem_Wdata = req_wdata[REQ_DCACHE];
    end else if (gnt[REQ_ICACHE]) begin
      mem_Wdata = req_wdata[REQ_ICACHE];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      ack       <= '0;
      last      <= 1'b0;
      beat      <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_Write <= 1'b0;
      mem_addr  <= '0;
      base      <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_prio   <= 1'b0;
`endif
    end else begin
      ack     <= '0;
      last    <= 1'b0;
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt       <= {win, ~win};
            mem_Write <= req_write[win];
            base      <= win_base;
            beat      <= '0;
            mem_addr  <= win_base;
            mem_req   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mem_Done) begin
            rdata <= mem_Rdata;
            ack   <= gnt;
            if (beat == LAST_BEAT) begin
              last  <= 1'b1;
              gnt   <= '0;
              state <= IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
              rr_prio <= ~gnt[REQ_DCACHE];
`endif
            end else begin
              beat     <= beat_inc;
              mem_addr <= base + ADDR_SZ'({beat_inc, 2'b00});
              mem_req  <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of burst scenarios with a
// scoreboard of expected memory commands and acks, plus a mid-burst reset.
module tb_mem_arbiter;

  localparam int BL = 4;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam logic TIE_FIRST = 1'b1;
`else
  localparam logic TIE_FIRST = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [9:0]  a0;
    logic [9:0]  a1;
    int          lat;
    logic [31:0] wb0;
    logic [31:0] wb1;
    logic        first;
  } vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
  } cmd_t;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        last;
  } ack_t;

  logic             clock;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0][9:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       gnt;
  logic [1:0]       beat;
  logic [1:0]       ack;
  logic             last;
  logic [31:0]      rdata;
  logic             mem_req;
  logic             mem_Write;
  logic [9:0]       mem_addr;
  logic [31:0]      mem_Wdata;
  logic [31:0]      mem_Rdata;
  logic             mem_Done;

  logic [31:0] wb0;
  logic [31:0] wb1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_seq = 0;
  int applied_seq = 0;
  int nreq = 0;
  int nack = 0;
  int ndone = 0;
  vec_t cur;

  cmd_t exp_cmd[$];
  ack_t exp_ack[$];

  mem_arbiter #(.ADDR_SZ(10), .DATA_SZ(32), .BURST_LEN(BL)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .beat      (beat),
    .ack       (ack),
    .last      (last),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_Write (mem_Write),
    .mem_addr  (mem_addr),
    .mem_Wdata (mem_Wdata),
    .mem_Rdata (mem_Rdata),
    .mem_Done  (mem_Done)
  );

  // Requesters drive their write word from the current beat.
  assign req_wdata[0] = wb0 + 32'(beat);
  assign req_wdata[1] = wb1 + 32'(beat);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_fn(input logic [9:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int w);
    logic [9:0] base;
    cmd_t c;
    ack_t a;
    base = ((w == 0) ? cur.a0 : cur.a1) & 10'h3F0;
    for (int b = 0; b < BL; b++) begin
      c.addr  = base + 10'(4 * b);
      c.wr    = cur.write[w];
      c.wdata = ((w == 0) ? cur.wb0 : cur.wb1) + 32'(b);
      c.gnt   = 2'b01 << w;
      exp_cmd.push_back(c);
      a.ack   = c.gnt;
      a.rdata = mem_fn(c.addr);
      a.last  = (b == BL - 1);
      exp_ack.push_back(a);
    end
  endtask

  // Requester, memory model and scoreboard monitor, all on the falling edge.
  initial begin
    int   lat;
    int   cnt;
    bit   pending;
    bit   chk_stable;
    int   start [2];
    bit   lat_chk [2];
    logic [9:0]  l_addr;
    logic        l_wr;
    logic [31:0] l_wdata;
    cmd_t ec;
    ack_t ea;
    int   wi;

    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    wb0       = 32'h0;
    wb1       = 32'h0;
    mem_Done  = 1'b0;
    mem_Rdata = 32'h0;
    lat = 1; cnt = 0; pending = 0; chk_stable = 0;
    l_addr = '0; l_wr = 1'b0; l_wdata = '0;
    start[0] = 0; start[1] = 0; lat_chk[0] = 0; lat_chk[1] = 0;

    forever begin
      @(negedge clock);
      mem_Done = 1'b0;

      if (!reset_n) begin
        exp_cmd.delete();
        exp_ack.delete();
        req_valid = 2'b00;
        chk_stable = 0;
        lat_chk[0] = 0;
        lat_chk[1] = 0;
      end

      if (pending) begin
        if (chk_stable && reset_n) begin
          chk("cmd_stable_addr", mem_addr, l_addr);
          chk("cmd_stable_write", mem_Write, l_wr);
          chk("cmd_stable_wdata", mem_Wdata, l_wdata);
          chk("single_mem_req", mem_req, 1'b0);
        end
        cnt--;
        if (cnt == 0) begin
          mem_Done  = 1'b1;
          mem_Rdata = mem_fn(l_addr);
          pending   = 0;
          ndone++;
        end
      end

      if (reset_n && mem_req) begin
        nreq++;
        chk("mem_req_expected", 32'(exp_cmd.size() != 0), 1);
        if (exp_cmd.size() != 0) begin
          ec = exp_cmd.pop_front();
          chk("mem_addr", mem_addr, ec.addr);
          chk("mem_Write", mem_Write, ec.wr);
          chk("mem_Wdata", mem_Wdata, ec.wdata);
          chk("gnt", gnt, ec.gnt);
        end
        pending = 1; cnt = lat; chk_stable = 1;
        l_addr = mem_addr; l_wr = mem_Write; l_wdata = mem_Wdata;
      end

      if (reset_n && ack != 2'b00) begin
        nack++;
        chk("ack_expected", 32'(exp_ack.size() != 0), 1);
        if (exp_ack.size() != 0) begin
          ea = exp_ack.pop_front();
          $display("ack %b rdata %08h last %0d", ack, rdata, last);
          chk("ack", ack, ea.ack);
          chk("rdata", rdata, ea.rdata);
          chk("last", last, ea.last);
          if (ea.last) begin
            wi = ea.ack[1] ? 1 : 0;
            req_valid[wi] = 1'b0;
            if (lat_chk[wi]) chk("burst_cycles", 64'(cyc - start[wi]), 64'(BL * (lat + 1) + 1));
            lat_chk[wi] = 0;
          end
        end
      end

      if (reset_n && go_seq != applied_seq) begin
        req_write   = cur.write;
        req_addr[0] = cur.a0;
        req_addr[1] = cur.a1;
        wb0 = cur.wb0;
        wb1 = cur.wb1;
        lat = cur.lat;
        for (int k = 0; k < 2; k++) begin
          wi = (k == 0) ? int'(cur.first) : 1 - int'(cur.first);
          if (cur.valid[wi]) begin
            push_burst(wi);
            start[wi]   = cyc;
            lat_chk[wi] = (k == 0);
          end
        end
        req_valid   = cur.valid;
        applied_seq = go_seq;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_beat"}, beat, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_Write"}, mem_Write, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_Wdata"}, mem_Wdata, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    cur = v;
    go_seq++;
    t = 0;
    while ((applied_seq != go_seq || req_valid != 2'b00) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk("burst_timeout", 32'(t >= 2000), 0);
    chk("scoreboard_drained", 32'(exp_cmd.size() + exp_ack.size()), 0);
    @(negedge clock);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t rv;
    int   n0, na, nr, nd, t;

    tbl[0] = '{1'b0, 2'b01, 2'b00, 10'h046, 10'h000, 1, 32'h10, 32'h0,  1'b0};
    tbl[1] = '{1'b0, 2'b10, 2'b10, 10'h000, 10'h3F0, 1, 32'h0,  32'hA0, 1'b1};
    tbl[2] = '{1'b1, 2'b11, 2'b00, 10'h100, 10'h200, 1, 32'h20, 32'h60, TIE_FIRST};
    tbl[3] = '{1'b0, 2'b01, 2'b01, 10'h080, 10'h000, 5, 32'h55, 32'h0,  1'b0};
    tbl[4] = '{1'b0, 2'b01, 2'b00, 10'h3F8, 10'h000, 1, 32'h0,  32'h0,  1'b0};
    tbl[5] = '{1'b0, 2'b11, 2'b11, 10'h300, 10'h010, 2, 32'h30, 32'h40, 1'b1};
    tbl[6] = '{1'b0, 2'b10, 2'b00, 10'h000, 10'h123, 1, 32'h0,  32'h70, 1'b1};

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst) begin
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
      end
      $display("vector %0d: valid %b write %b lat %0d", i, tbl[i].valid, tbl[i].write, tbl[i].lat);
      run_vec(tbl[i]);
    end

    // Reset while waiting on beat 2; the memory completion then lands after release.
    rv = '{1'b0, 2'b01, 2'b00, 10'h040, 10'h000, 6, 32'h0, 32'h0, 1'b0};
    n0 = nreq;
    cur = rv;
    go_seq++;
    t = 0;
    while (nreq < n0 + 3 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("reach_beat2_timeout", 32'(t >= 200), 0);
    @(negedge clock);
    chk("beat_before_reset", beat, 2);
    reset_n = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    na = nack;
    nr = nreq;
    nd = ndone;
    repeat (12) @(negedge clock);
    chk("late_done_delivered", 32'(ndone > nd), 1);
    chk("late_done_no_ack", 32'(nack - na), 0);
    chk("no_req_after_reset", 32'(nreq - nr), 0);
    chk("idle_gnt_after_reset", gnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
